// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: payload in, forwarding taps, retire port and counters of the stage chain
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic                   stall;
    logic [DEPTH-1:0]       flush;
    logic [DEPTH-1:0]       tap_valid;
    logic [DEPTH*WIDTH-1:0] tap_data;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [CNT_W-1:0]       retire_count;
    logic [CNT_W-1:0]       stall_count;

    modport master (
        output in_valid, in_data, stall, flush,
        input  in_ready, tap_valid, tap_data, out_valid, out_data, retire_count, stall_count
    );

    modport slave (
        input  in_valid, in_data, stall, flush,
        output in_ready, tap_valid, tap_data, out_valid, out_data, retire_count, stall_count
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: valid+payload register chain with load-use stall, per-stage flush and perf counters
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_stage_chain_if.slave bus
);
    generate
        if (DEPTH < 2 || HOLD < 1 || HOLD > DEPTH - 1) begin : g_bad_params
            $error("pipe_stage_chain: requires DEPTH >= 2 and 1 <= HOLD <= DEPTH-1");
        end
    endgenerate

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] pv;
    logic [DEPTH-1:0] nv;
    logic [WIDTH-1:0] d  [DEPTH];
    logic [WIDTH-1:0] pd [DEPTH];
    logic [WIDTH-1:0] nd [DEPTH];
    logic [CNT_W-1:0] retire_count;
    logic [CNT_W-1:0] stall_count;

    assign pv = {v[DEPTH-2:0], bus.in_valid};

    // Next stage contents: hold below HOLD on stall, bubble at HOLD, flush wins, bubbles carry zero
    always_comb begin
        pd[0] = bus.in_data;
        for (int i = 1; i < DEPTH; i++) pd[i] = d[i-1];
        for (int i = 0; i < DEPTH; i++) begin
            nv[i] = ~bus.flush[i] & ((bus.stall && i < HOLD) ? v[i] : (bus.stall && i == HOLD) ? 1'b0 : pv[i]);
            nd[i] = nv[i] ? ((bus.stall && i < HOLD) ? d[i] : pd[i]) : '0;
        end
    end

    // Stage registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            v <= nv;
            for (int i = 0; i < DEPTH; i++) d[i] <= nd[i];
        end
    end

    // Retire counter wraps; stall counter saturates at all-ones
    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_count <= '0;
            stall_count  <= '0;
        end else begin
            retire_count <= retire_count + CNT_W'(v[DEPTH-1]);
            stall_count  <= (bus.stall && stall_count != '1) ? stall_count + 1'b1 : stall_count;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign bus.tap_data[g*WIDTH +: WIDTH] = d[g];
    end

    assign bus.tap_valid    = v;
    assign bus.out_valid    = v[DEPTH-1];
    assign bus.out_data     = d[DEPTH-1];
    assign bus.in_ready     = ~bus.stall;
    assign bus.retire_count = retire_count;
    assign bus.stall_count  = stall_count;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed scenarios plus random traffic checked against a slot-array model
module tb_pipe_stage_chain;
    localparam int W = 32;
    localparam int D = 4;
    localparam int H = 2;
    localparam int C = 16;

    logic clk = 0;
    logic reset = 1;
    int checks = 0;
    int failures = 0;
    bit known = 0;

    pipe_stage_chain_if #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) bus ();

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .HOLD(H), .CNT_W(C)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the pipe is a row of slots; each edge the row slides by one, except that on a
    // stall the front HOLD slots stay put and an empty slot opens behind them; flushed slots empty.
    logic        mv [D];
    logic [31:0] md [D];
    logic        tv [D];
    logic [31:0] td [D];
    int mret = 0;
    int mstall = 0;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) begin
                mv[i] <= 0;
                md[i] <= 0;
            end
            mret <= 0;
            mstall <= 0;
            known <= 1;
        end else begin
            for (int i = 0; i < D; i++) begin
                tv[i] = mv[i];
                td[i] = md[i];
            end
            if (bus.stall) begin
                for (int i = D - 1; i > H; i--) begin
                    tv[i] = mv[i-1];
                    td[i] = md[i-1];
                end
                tv[H] = 0;
            end else begin
                for (int i = D - 1; i > 0; i--) begin
                    tv[i] = mv[i-1];
                    td[i] = md[i-1];
                end
                tv[0] = bus.in_valid;
                td[0] = bus.in_data;
            end
            for (int i = 0; i < D; i++) begin
                mv[i] <= tv[i] && !bus.flush[i];
                md[i] <= (tv[i] && !bus.flush[i]) ? td[i] : 32'h0;
            end
            mret <= (mret + (mv[D-1] ? 1 : 0)) % 65536;
            mstall <= (bus.stall && mstall < 65535) ? mstall + 1 : mstall;
        end
    end

    // Compare every cycle once the model has been aligned by a reset
    always @(negedge clk) begin
        if (known && reset) begin
            for (int i = 0; i < D; i++) begin
                chk($sformatf("tap_valid%0d", i), 64'(bus.tap_valid[i]), 64'(mv[i]));
                chk($sformatf("tap_data%0d", i), 64'(bus.tap_data[i*W +: W]), 64'(md[i]));
            end
            chk("out_valid", 64'(bus.out_valid), 64'(mv[D-1]));
            chk("out_data", 64'(bus.out_data), 64'(md[D-1]));
            chk("retire_count", 64'(bus.retire_count), 64'(mret));
            chk("stall_count", 64'(bus.stall_count), 64'(mstall));
            chk("in_ready", 64'(bus.in_ready), 64'(!bus.stall));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] dat);
        bus.in_valid = vld;
        bus.in_data = dat;
    endtask

    task automatic drain();
        drive(0, 0);
        bus.stall = 0;
        bus.flush = 0;
        repeat (D) step();
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.stall = 0;
        bus.flush = 0;
        #1;
        // 1: scramble state, then a single reset edge
        repeat (5) begin
            drive(1'($urandom), $urandom);
            bus.stall = 1'($urandom);
            step();
        end
        drive(0, 0);
        bus.stall = 0;
        reset = 0;
        step();
        reset = 1;
        chk("rst_tap_valid", 64'(bus.tap_valid), 64'h0);
        chk("rst_tap_data", 64'(bus.tap_data == '0), 64'h1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_retire", 64'(bus.retire_count), 64'h0);
        chk("rst_stall", 64'(bus.stall_count), 64'h0);

        // 2: three back-to-back entries, first shows after the 4th edge
        drive(1, 32'h11); step();
        drive(1, 32'h22); step();
        drive(1, 32'h33); step();
        drive(0, 0);      step();
        chk("lat_v0", 64'(bus.out_valid), 64'h1);
        chk("lat_d0", 64'(bus.out_data), 64'h11);
        step();
        chk("lat_d1", 64'(bus.out_data), 64'h22);
        step();
        chk("lat_d2", 64'(bus.out_data), 64'h33);
        step();
        chk("lat_end", 64'(bus.out_valid), 64'h0);
        chk("lat_retire", 64'(bus.retire_count), 64'h3);

        // 3: one stall cycle with s0=B, s1=A
        drain();
        drive(1, 32'hA); step();
        drive(1, 32'hB); step();
        drive(1, 32'hC);
        bus.stall = 1;
        #1;
        chk("stall_in_ready", 64'(bus.in_ready), 64'h0);
        step();
        chk("stall_s0", 64'(bus.tap_data[0 +: W]), 64'hB);
        chk("stall_s1", 64'(bus.tap_data[W +: W]), 64'hA);
        chk("stall_s2v", 64'(bus.tap_valid[2]), 64'h0);
        chk("stall_s2d", 64'(bus.tap_data[2*W +: W]), 64'h0);
        chk("stall_cnt", 64'(bus.stall_count), 64'h1);
        bus.stall = 0;
        drive(0, 0);
        step();
        chk("stall_late", 64'(bus.out_valid), 64'h0);
        step();
        chk("stall_out_v", 64'(bus.out_valid), 64'h1);
        chk("stall_out_d", 64'(bus.out_data), 64'hA);

        // 4: flush the two youngest stages of a full pipe
        drain();
        drive(1, 32'hA); step();
        drive(1, 32'hB); step();
        drive(1, 32'hC); step();
        drive(1, 32'hD); step();
        drive(1, 32'hE);
        bus.flush = 4'b0011;
        chk("fl_out_v", 64'(bus.out_valid), 64'h1);
        chk("fl_out_d", 64'(bus.out_data), 64'hA);
        step();
        bus.flush = 0;
        drive(0, 0);
        chk("fl_valid", 64'(bus.tap_valid), 64'b1100);
        chk("fl_s0d", 64'(bus.tap_data[0 +: W]), 64'h0);
        chk("fl_s1d", 64'(bus.tap_data[W +: W]), 64'h0);
        chk("fl_s2d", 64'(bus.tap_data[2*W +: W]), 64'hC);
        chk("fl_s3d", 64'(bus.tap_data[3*W +: W]), 64'hB);

        // 5: flush of a held stage beats the stall
        drain();
        drive(1, 32'hA); step();
        drive(1, 32'hB); step();
        drive(0, 0);
        bus.stall = 1;
        bus.flush = 4'b0001;
        step();
        bus.stall = 0;
        bus.flush = 0;
        chk("sf_valid", 64'(bus.tap_valid[2:0]), 64'b010);
        chk("sf_s0d", 64'(bus.tap_data[0 +: W]), 64'h0);
        chk("sf_s1d", 64'(bus.tap_data[W +: W]), 64'hA);

        // 6: reset in the middle of a 3-cycle stall on a full pipe
        drain();
        for (int i = 1; i <= D; i++) begin
            drive(1, 32'(i * 16'h101));
            step();
        end
        bus.stall = 1;
        step();
        reset = 0;
        step();
        reset = 1;
        chk("mid_rst_valid", 64'(bus.tap_valid), 64'h0);
        chk("mid_rst_stall", 64'(bus.stall_count), 64'h0);
        chk("mid_rst_retire", 64'(bus.retire_count), 64'h0);
        step();
        chk("resume_stall", 64'(bus.stall_count), 64'h1);
        chk("resume_valid", 64'(bus.tap_valid), 64'h0);
        bus.stall = 0;

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom);
            bus.stall = ($urandom_range(0, 9) < 3);
            bus.flush = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
            reset = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
